// File: rtl/reindeer_writeback_if.sv
// Write-back stage bus: execute results, load issue/response, hazard query, register-file write port.
// Latency: none; this is pure wiring between the upstream pipeline and the write-back stage.
// Backpressure: wb_stall throttles exe_*; load responses cannot be back-pressured.
interface reindeer_writeback_if #(
    parameter int XLEN          = 32,
    parameter int REG_ADDR_BITS = 5
);
    logic                     exe_valid;
    logic [REG_ADDR_BITS-1:0] exe_rd;
    logic [XLEN-1:0]          exe_data;
    logic                     wb_stall;
    logic                     ld_issue;
    logic [REG_ADDR_BITS-1:0] ld_issue_rd;
    logic                     ld_valid;
    logic [XLEN-1:0]          ld_data;
    logic [1:0]               ld_byte_offset;
    logic [1:0]               ld_width;
    logic                     ld_unsigned;
    logic [REG_ADDR_BITS-1:0] hz_rs1_addr;
    logic [REG_ADDR_BITS-1:0] hz_rs2_addr;
    logic                     load_use_hazard;
    logic                     protocol_err;
    logic                     write_enable;
    logic [REG_ADDR_BITS-1:0] write_addr;
    logic [XLEN-1:0]          write_data;

    // Upstream pipeline / memory side / decode side.
    modport master (
        output exe_valid, exe_rd, exe_data,
        output ld_issue, ld_issue_rd,
        output ld_valid, ld_data, ld_byte_offset, ld_width, ld_unsigned,
        output hz_rs1_addr, hz_rs2_addr,
        input  wb_stall, load_use_hazard, protocol_err,
        input  write_enable, write_addr, write_data
    );

    // The write-back stage itself.
    modport slave (
        input  exe_valid, exe_rd, exe_data,
        input  ld_issue, ld_issue_rd,
        input  ld_valid, ld_data, ld_byte_offset, ld_width, ld_unsigned,
        input  hz_rs1_addr, hz_rs2_addr,
        output wb_stall, load_use_hazard, protocol_err,
        output write_enable, write_addr, write_data
    );
endinterface

// File: rtl/reindeer_writeback_stage.sv
// Merges load responses and execute results onto the single register-file write port.
// Latency: 1 cycle from acceptance (or load response) to write_enable.
// Backpressure: one-entry holding buffer; wb_stall (registered) = buffer full, loads never stall.
module reindeer_writeback_stage #(
    parameter int XLEN          = 32,
    parameter int REG_ADDR_BITS = 5
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 sync_reset,
    reindeer_writeback_if.slave  wb
);

    // Scoreboard: the single outstanding load destination.
    logic                     outstanding;
    logic [REG_ADDR_BITS-1:0] sb_rd;

    // Holding buffer for an execute result that lost the write slot to a load.
    logic                     buf_vld;
    logic [REG_ADDR_BITS-1:0] buf_rd;
    logic [XLEN-1:0]          buf_data;

    // Registered outputs.
    logic                     err_q;
    logic                     we_q;
    logic [REG_ADDR_BITS-1:0] addr_q;
    logic [XLEN-1:0]          data_q;

    // Next-state values.
    logic                     outstanding_n;
    logic [REG_ADDR_BITS-1:0] sb_rd_n;
    logic                     buf_vld_n;
    logic [REG_ADDR_BITS-1:0] buf_rd_n;
    logic [XLEN-1:0]          buf_data_n;
    logic                     err_n;
    logic                     we_n;
    logic [REG_ADDR_BITS-1:0] addr_n;
    logic [XLEN-1:0]          data_n;

    // Qualified events.
    logic ld_fire;
    logic ld_orphan;
    logic ld_write;
    logic exe_live;
    logic issue_ok;
    logic issue_bad;

    // Load formatting.
    logic [7:0]      byte_sel;
    logic [15:0]     half_sel;
    logic [XLEN-1:0] ld_fmt;

    // A response only counts when a load is outstanding; a load to x0 retires without a write.
    assign ld_fire   = wb.ld_valid && outstanding;
    assign ld_orphan = wb.ld_valid && !outstanding;
    assign ld_write  = ld_fire && (sb_rd != '0);

    // wb_stall is the buffer-full flag, so an exe result is only accepted into an empty buffer path.
    assign exe_live  = wb.exe_valid && !buf_vld && (wb.exe_rd != '0);

    // A new load may be recorded when the slot is free or frees up this same cycle.
    assign issue_ok  = wb.ld_issue && (!outstanding || wb.ld_valid);
    assign issue_bad = wb.ld_issue && outstanding && !wb.ld_valid;

    // Select the addressed byte/halfword and extend; word widths pass the memory word through.
    always_comb begin
        byte_sel = 8'h00;
        half_sel = 16'h0000;
        ld_fmt   = wb.ld_data;
        case (wb.ld_byte_offset)
            2'd0:    byte_sel = wb.ld_data[7:0];
            2'd1:    byte_sel = wb.ld_data[15:8];
            2'd2:    byte_sel = wb.ld_data[23:16];
            default: byte_sel = wb.ld_data[31:24];
        endcase
        // Bit 0 of the offset is ignored for halfwords; misalignment is trapped upstream.
        half_sel = wb.ld_byte_offset[1] ? wb.ld_data[31:16] : wb.ld_data[15:0];
        case (wb.ld_width)
            2'b00:   ld_fmt = {{(XLEN-8){byte_sel[7] & ~wb.ld_unsigned}}, byte_sel};
            2'b01:   ld_fmt = {{(XLEN-16){half_sel[15] & ~wb.ld_unsigned}}, half_sel};
            default: ld_fmt = wb.ld_data;
        endcase
    end

    // Arbitrate the write slot (load > buffer > new exe) and compute scoreboard/buffer next state.
    always_comb begin
        we_n          = 1'b0;
        addr_n        = '0;
        data_n        = '0;
        buf_vld_n     = buf_vld;
        buf_rd_n      = buf_rd;
        buf_data_n    = buf_data;
        outstanding_n = outstanding;
        sb_rd_n       = sb_rd;
        err_n         = err_q | issue_bad | ld_orphan;

        if (ld_write) begin
            we_n   = 1'b1;
            addr_n = sb_rd;
            data_n = ld_fmt;
            // The exe result that lost the slot parks in the buffer; a full buffer simply holds.
            if (!buf_vld && exe_live) begin
                buf_vld_n  = 1'b1;
                buf_rd_n   = wb.exe_rd;
                buf_data_n = wb.exe_data;
            end
        end else if (buf_vld) begin
            we_n      = 1'b1;
            addr_n    = buf_rd;
            data_n    = buf_data;
            buf_vld_n = 1'b0;
        end else if (exe_live) begin
            we_n   = 1'b1;
            addr_n = wb.exe_rd;
            data_n = wb.exe_data;
        end

        if (ld_fire) begin
            outstanding_n = 1'b0;
        end
        if (issue_ok) begin
            outstanding_n = 1'b1;
            sb_rd_n       = wb.ld_issue_rd;
        end
    end

    // State and output registers; either reset discards buffered results and the outstanding load.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            outstanding <= 1'b0;
            sb_rd       <= '0;
            buf_vld     <= 1'b0;
            buf_rd      <= '0;
            buf_data    <= '0;
            err_q       <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
        end else if (sync_reset) begin
            outstanding <= 1'b0;
            sb_rd       <= '0;
            buf_vld     <= 1'b0;
            buf_rd      <= '0;
            buf_data    <= '0;
            err_q       <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
        end else begin
            outstanding <= outstanding_n;
            sb_rd       <= sb_rd_n;
            buf_vld     <= buf_vld_n;
            buf_rd      <= buf_rd_n;
            buf_data    <= buf_data_n;
            err_q       <= err_n;
            we_q        <= we_n;
            addr_q      <= addr_n;
            data_q      <= data_n;
        end
    end

    // Hazard drops as soon as the response arrives; the register file forwards that same-cycle write.
    assign wb.load_use_hazard = outstanding && (sb_rd != '0) && !wb.ld_valid &&
                                ((wb.hz_rs1_addr == sb_rd) || (wb.hz_rs2_addr == sb_rd));

    assign wb.wb_stall     = buf_vld;
    assign wb.protocol_err = err_q;
    assign wb.write_enable = we_q;
    assign wb.write_addr   = addr_q;
    assign wb.write_data   = data_q;

endmodule

// File: tb/tb_reindeer_writeback_stage.sv
// Directed bench for the write-back stage: vector table plus reset/protocol sequences.
// Latency: registered outputs checked 1 ns after each rising edge, hazard checked mid-cycle.
// Backpressure: stall behaviour is part of the expected values in the table.
module tb_reindeer_writeback_stage;

    logic clk;
    logic reset_n;
    logic sync_reset;

    int n_tests;
    int n_fail;

    reindeer_writeback_if #(.XLEN(32), .REG_ADDR_BITS(5)) bus ();

    reindeer_writeback_stage #(.XLEN(32), .REG_ADDR_BITS(5)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .sync_reset (sync_reset),
        .wb         (bus)
    );

    typedef struct {
        logic        ev;
        logic [4:0]  erd;
        logic [31:0] edat;
        logic        li;
        logic [4:0]  lird;
        logic        lv;
        logic [31:0] ldat;
        logic [1:0]  off;
        logic [1:0]  wid;
        logic        uns;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        xwe;
        logic [4:0]  xaddr;
        logic [31:0] xdata;
        logic        xstall;
        logic        xhz;
        logic        xerr;
    } vec_t;

    localparam int NV = 35;
    localparam logic [31:0] D = 32'h80FF_7F01;
    vec_t vecs [NV];

    // Clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard time limit so the bench can never hang.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic vec_t mk(
        input logic ev, input logic [4:0] erd, input logic [31:0] edat,
        input logic li, input logic [4:0] lird,
        input logic lv, input logic [31:0] ldat, input logic [1:0] off,
        input logic [1:0] wid, input logic uns,
        input logic [4:0] rs1, input logic [4:0] rs2,
        input logic xwe, input logic [4:0] xaddr, input logic [31:0] xdata,
        input logic xstall, input logic xhz, input logic xerr);
        vec_t v;
        v.ev = ev; v.erd = erd; v.edat = edat; v.li = li; v.lird = lird;
        v.lv = lv; v.ldat = ldat; v.off = off; v.wid = wid; v.uns = uns;
        v.rs1 = rs1; v.rs2 = rs2; v.xwe = xwe; v.xaddr = xaddr; v.xdata = xdata;
        v.xstall = xstall; v.xhz = xhz; v.xerr = xerr;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.exe_valid      = 1'b0;
        bus.exe_rd         = '0;
        bus.exe_data       = '0;
        bus.ld_issue       = 1'b0;
        bus.ld_issue_rd    = '0;
        bus.ld_valid       = 1'b0;
        bus.ld_data        = '0;
        bus.ld_byte_offset = '0;
        bus.ld_width       = 2'b10;
        bus.ld_unsigned    = 1'b0;
        bus.hz_rs1_addr    = 5'd31;
        bus.hz_rs2_addr    = 5'd31;
    endtask

    task automatic drive(input vec_t v);
        bus.exe_valid      = v.ev;
        bus.exe_rd         = v.erd;
        bus.exe_data       = v.edat;
        bus.ld_issue       = v.li;
        bus.ld_issue_rd    = v.lird;
        bus.ld_valid       = v.lv;
        bus.ld_data        = v.ldat;
        bus.ld_byte_offset = v.off;
        bus.ld_width       = v.wid;
        bus.ld_unsigned    = v.uns;
        bus.hz_rs1_addr    = v.rs1;
        bus.hz_rs2_addr    = v.rs2;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_tests    = 0;
        n_fail     = 0;
        reset_n    = 1'b0;
        sync_reset = 1'b0;
        idle_inputs();

        //        ev erd   edat        li lird lv ldat          off   wid   uns rs1    rs2    we a     data          st hz er
        vecs[0]  = mk(0, 0, 0,          0, 0,  0, 0,            0,    2,    0,  31,    31,    0, 0,    0,            0, 0, 0);
        vecs[1]  = mk(1, 5, 32'h1234,   0, 0,  0, 0,            0,    2,    0,  31,    31,    1, 5,    32'h1234,     0, 0, 0);
        vecs[2]  = mk(0, 0, 0,          0, 0,  0, 0,            0,    2,    0,  31,    31,    0, 0,    0,            0, 0, 0);
        vecs[3]  = mk(0, 0, 0,          1, 7,  0, 0,            0,    2,    0,  31,    31,    0, 0,    0,            0, 0, 0);
        vecs[4]  = mk(0, 0, 0,          0, 0,  0, 0,            0,    2,    0,  7,     31,    0, 0,    0,            0, 1, 0);
        vecs[5]  = mk(0, 0, 0,          0, 0,  1, D,            3,    0,    0,  7,     31,    1, 7,    32'hFFFFFF80, 0, 0, 0);
        vecs[6]  = mk(0, 0, 0,          1, 7,  0, 0,            0,    2,    0,  31,    31,    0, 0,    0,            0, 0, 0);
        vecs[7]  = mk(0, 0, 0,          0, 0,  1, D,            3,    0,    1,  31,    31,    1, 7,    32'h00000080, 0, 0, 0);
        vecs[8]  = mk(0, 0, 0,          1, 7,  0, 0,            0,    2,    0,  31,    31,    0, 0,    0,            0, 0, 0);
        vecs[9]  = mk(0, 0, 0,          0, 0,  1, D,            2,    1,    0,  31,    31,    1, 7,    32'hFFFF80FF, 0, 0, 0);
        vecs[10] = mk(0, 0, 0,          1, 10, 0, 0,            0,    2,    0,  31,    31,    0, 0,    0,            0, 0, 0);
        vecs[11] = mk(0, 0, 0,          1, 11, 1, D,            0,    0,    1,  31,    31,    1, 10,   32'h00000001, 0, 0, 0);
        vecs[12] = mk(0, 0, 0,          1, 12, 1, D,            1,    0,    0,  31,    31,    1, 11,   32'h0000007F, 0, 0, 0);
        vecs[13] = mk(0, 0, 0,          1, 13, 1, D,            0,    1,    0,  31,    31,    1, 12,   32'h00007F01, 0, 0, 0);
        vecs[14] = mk(0, 0, 0,          1, 14, 1, D,            3,    1,    1,  31,    31,    1, 13,   32'h000080FF, 0, 0, 0);
        vecs[15] = mk(0, 0, 0,          0, 0,  1, D,            1,    3,    0,  31,    31,    1, 14,   32'h80FF7F01, 0, 0, 0);
        vecs[16] = mk(0, 0, 0,          1, 7,  0, 0,            0,    2,    0,  31,    31,    0, 0,    0,            0, 0, 0);
        vecs[17] = mk(1, 3, 32'h55,     0, 0,  1, 32'hAAAAAAAA, 0,    2,    0,  31,    31,    1, 7,    32'hAAAAAAAA, 1, 0, 0);
        vecs[18] = mk(0, 0, 0,          0, 0,  0, 0,            0,    2,    0,  31,    31,    1, 3,    32'h55,       0, 0, 0);
        vecs[19] = mk(0, 0, 0,          1, 8,  0, 0,            0,    2,    0,  31,    31,    0, 0,    0,            0, 0, 0);
        vecs[20] = mk(1, 4, 32'h44,     1, 9,  1, 32'h11112222, 0,    2,    0,  31,    31,    1, 8,    32'h11112222, 1, 0, 0);
        vecs[21] = mk(1, 6, 32'h66,     0, 0,  1, 32'h33334444, 0,    2,    0,  31,    31,    1, 9,    32'h33334444, 1, 0, 0);
        vecs[22] = mk(1, 6, 32'h66,     0, 0,  0, 0,            0,    2,    0,  31,    31,    1, 4,    32'h44,       0, 0, 0);
        vecs[23] = mk(1, 6, 32'h66,     0, 0,  0, 0,            0,    2,    0,  31,    31,    1, 6,    32'h66,       0, 0, 0);
        vecs[24] = mk(0, 0, 0,          0, 0,  0, 0,            0,    2,    0,  31,    31,    0, 0,    0,            0, 0, 0);
        vecs[25] = mk(0, 0, 0,          1, 9,  0, 0,            0,    2,    0,  31,    9,     0, 0,    0,            0, 0, 0);
        vecs[26] = mk(0, 0, 0,          0, 0,  0, 0,            0,    2,    0,  31,    9,     0, 0,    0,            0, 1, 0);
        vecs[27] = mk(0, 0, 0,          0, 0,  1, 32'h9,        0,    2,    0,  31,    9,     1, 9,    32'h9,        0, 0, 0);
        vecs[28] = mk(0, 0, 0,          0, 0,  0, 0,            0,    2,    0,  31,    9,     0, 0,    0,            0, 0, 0);
        vecs[29] = mk(0, 0, 0,          1, 0,  0, 0,            0,    2,    0,  0,     0,     0, 0,    0,            0, 0, 0);
        vecs[30] = mk(0, 0, 0,          0, 0,  0, 0,            0,    2,    0,  0,     0,     0, 0,    0,            0, 0, 0);
        vecs[31] = mk(0, 0, 0,          0, 0,  1, 32'h5,        0,    2,    0,  0,     0,     0, 0,    0,            0, 0, 0);
        vecs[32] = mk(1, 0, 32'h77,     0, 0,  0, 0,            0,    2,    0,  31,    31,    0, 0,    0,            0, 0, 0);
        vecs[33] = mk(0, 0, 0,          0, 0,  1, 32'h1,        0,    2,    0,  31,    31,    0, 0,    0,            0, 0, 1);
        vecs[34] = mk(0, 0, 0,          0, 0,  0, 0,            0,    2,    0,  31,    31,    0, 0,    0,            0, 0, 1);

        // Reset state.
        repeat (3) step();
        chk("rst_we",    32'(bus.write_enable), 32'd0);
        chk("rst_addr",  32'(bus.write_addr),   32'd0);
        chk("rst_data",  bus.write_data,        32'd0);
        chk("rst_stall", 32'(bus.wb_stall),     32'd0);
        chk("rst_err",   32'(bus.protocol_err), 32'd0);
        reset_n = 1'b1;
        step();

        // Table: hazard is checked mid-cycle, registered outputs just after the edge.
        for (int i = 0; i < NV; i++) begin
            drive(vecs[i]);
            #1;
            chk($sformatf("v%0d_hz", i), 32'(bus.load_use_hazard), 32'(vecs[i].xhz));
            step();
            chk($sformatf("v%0d_we", i), 32'(bus.write_enable), 32'(vecs[i].xwe));
            if (vecs[i].xwe) begin
                chk($sformatf("v%0d_addr", i), 32'(bus.write_addr), 32'(vecs[i].xaddr));
                chk($sformatf("v%0d_data", i), bus.write_data, vecs[i].xdata);
            end
            chk($sformatf("v%0d_stall", i), 32'(bus.wb_stall), 32'(vecs[i].xstall));
            chk($sformatf("v%0d_err", i), 32'(bus.protocol_err), 32'(vecs[i].xerr));
        end
        idle_inputs();

        // Async reset mid-operation discards the buffered exe result and the outstanding load.
        bus.ld_issue = 1'b1; bus.ld_issue_rd = 5'd1;
        step();
        bus.ld_issue    = 1'b1; bus.ld_issue_rd = 5'd1;
        bus.ld_valid    = 1'b1; bus.ld_data     = 32'hCAFE0001;
        bus.exe_valid   = 1'b1; bus.exe_rd      = 5'd2; bus.exe_data = 32'hDEAD0002;
        step();
        idle_inputs();
        bus.hz_rs1_addr = 5'd1;
        #1;
        chk("ar_pre_we",    32'(bus.write_enable), 32'd1);
        chk("ar_pre_addr",  32'(bus.write_addr),   32'd1);
        chk("ar_pre_stall", 32'(bus.wb_stall),     32'd1);
        chk("ar_pre_hz",    32'(bus.load_use_hazard), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("ar_stall", 32'(bus.wb_stall),        32'd0);
        chk("ar_we",    32'(bus.write_enable),    32'd0);
        chk("ar_err",   32'(bus.protocol_err),    32'd0);
        chk("ar_hz",    32'(bus.load_use_hazard), 32'd0);
        step();
        reset_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk($sformatf("ar_post%0d_we", k), 32'(bus.write_enable), 32'd0);
            chk($sformatf("ar_post%0d_stall", k), 32'(bus.wb_stall), 32'd0);
        end

        // Second issue while outstanding is ignored and flags an error; first rd is kept.
        bus.ld_issue = 1'b1; bus.ld_issue_rd = 5'd2;
        step();
        chk("pe_err0", 32'(bus.protocol_err), 32'd0);
        bus.ld_issue = 1'b1; bus.ld_issue_rd = 5'd3;
        step();
        chk("pe_err1", 32'(bus.protocol_err), 32'd1);
        idle_inputs();
        bus.hz_rs1_addr = 5'd3;
        #1;
        chk("pe_hz_rd3", 32'(bus.load_use_hazard), 32'd0);
        bus.hz_rs1_addr = 5'd2;
        #1;
        chk("pe_hz_rd2", 32'(bus.load_use_hazard), 32'd1);
        bus.ld_valid = 1'b1; bus.ld_data = 32'h0000BEEF;
        step();
        idle_inputs();
        chk("pe_wr_we",   32'(bus.write_enable), 32'd1);
        chk("pe_wr_addr", 32'(bus.write_addr),   32'd2);
        chk("pe_wr_data", bus.write_data,        32'h0000BEEF);

        // Synchronous reset clears the sticky error and the scoreboard.
        bus.ld_issue = 1'b1; bus.ld_issue_rd = 5'd5;
        step();
        idle_inputs();
        sync_reset = 1'b1;
        #1;
        chk("sr_err_held", 32'(bus.protocol_err), 32'd1);
        step();
        sync_reset = 1'b0;
        chk("sr_err", 32'(bus.protocol_err), 32'd0);
        chk("sr_we",  32'(bus.write_enable), 32'd0);
        bus.ld_valid = 1'b1; bus.ld_data = 32'h12345678;
        step();
        idle_inputs();
        chk("sr_orphan_we",  32'(bus.write_enable), 32'd0);
        chk("sr_orphan_err", 32'(bus.protocol_err), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/reindeer_writeback_stage.md
Name: reindeer_writeback_stage

Overview:
- Write-back stage directly upstream of the register file.
- Merges execute-unit results and load-data responses onto the single register-file write port (write_enable / write_addr / write_data).
- Formats load data with byte/halfword select and sign or zero extension.
- Tracks the one outstanding load destination and flags load-use hazards to decode.

Parameters:
XLEN, 32, data width
REG_ADDR_BITS, 5, register address width

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
sync_reset  in  1  synchronous reset, same effect as reset_n
exe_valid  in  1  execute result valid
exe_rd  in  REG_ADDR_BITS  execute destination register
exe_data  in  XLEN  execute result
wb_stall  out  1  holding buffer full; upstream must hold exe_*
ld_issue  in  1  load issued to memory this cycle
ld_issue_rd  in  REG_ADDR_BITS  destination of issued load
ld_valid  in  1  load response valid; cannot be back-pressured
ld_data  in  XLEN  raw aligned memory word
ld_byte_offset  in  2  address bits [1:0] of the load
ld_width  in  2  00 byte, 01 half, 10/11 word
ld_unsigned  in  1  1 = zero-extend, 0 = sign-extend
hz_rs1_addr  in  REG_ADDR_BITS  decode source 1
hz_rs2_addr  in  REG_ADDR_BITS  decode source 2
load_use_hazard  out  1  combinational hazard flag
protocol_err  out  1  sticky protocol-error flag
write_enable  out  1  register-file write strobe
write_addr  out  REG_ADDR_BITS  register-file write address
write_data  out  XLEN  register-file write data

Behaviour:
- Reset (async reset_n low, or sync_reset at a clock edge): all outputs 0; holding buffer empty; scoreboard clear; protocol_err cleared. A reset mid-operation discards any buffered result and any outstanding load.
- All write_* outputs are registered. Latency is 1 cycle from acceptance to write_enable=1.
- Accept rule: an exe result is accepted when exe_valid && !wb_stall. wb_stall is registered and equals "holding buffer full".
- Per-cycle priority for the write slot: ld_valid (with a load outstanding) > holding buffer > newly accepted exe result.
- Load and new exe in the same cycle, buffer empty: load is written; exe is captured into the buffer; wb_stall=1 next cycle.
- Buffer full, no ld_valid: buffer drains to the write port; wb_stall=0 the following cycle.
- Buffer full, ld_valid: load is written; buffer is held.
- Destination x0: write_enable stays 0 and no buffer slot is used. A load to x0 still clears the scoreboard.
- Load formatting, with off = ld_byte_offset:
  - byte: ld_data[8*off+7 : 8*off], extended to XLEN.
  - half: off[1]=0 selects [15:0], off[1]=1 selects [31:16]; off[0] is ignored (misalignment is trapped elsewhere); result is extended.
  - word (10 or 11): ld_data unchanged.
- Scoreboard: a single entry {outstanding, rd}.
  - ld_issue sets the entry.
  - ld_valid clears it; the write address is the stored rd.
  - ld_issue and ld_valid in the same cycle: the response completes and the new load is recorded.
  - ld_issue while outstanding with no ld_valid: ignored, protocol_err <= 1.
  - ld_valid with nothing outstanding: no write, protocol_err <= 1.
- load_use_hazard = outstanding && rd != 0 && (hz_rs1_addr == rd || hz_rs2_addr == rd). It is combinational on the registered scoreboard and drops in the cycle the response arrives.
- Register-file forwarding covers the write-to-read same-cycle case; this block provides no bypass.

Test Plan:
- Single exe_valid, rd=5, data=0x1234 -> next cycle write_enable=1, addr=5, data=0x1234; then write_enable=0.
- Load issue rd=7; response ld_data=0x80FF_7F01:
  - width byte, off=3, signed -> write 0xFFFF_FF80.
  - width byte, off=3, unsigned -> write 0x0000_0080.
  - width half, off=2, signed -> write 0xFFFF_80FF.
- Same cycle ld_valid (rd=7, word 0xAAAA_AAAA) and exe_valid (rd=3, 0x55) -> cycle+1: write r7=0xAAAA_AAAA, wb_stall=1; cycle+2: write r3=0x55; cycle+3: wb_stall=0.
- Load outstanding rd=9; hz_rs2_addr=9 -> load_use_hazard=1 until ld_valid, then 0 in that cycle. Repeat with rd=0 -> hazard never asserts and no write occurs.
- ld_valid with no outstanding load -> no write, protocol_err=1 and stays set until reset.
- exe captured in buffer, then reset_n pulsed low -> wb_stall=0, no later write of the buffered value, write_enable=0.
